gauss_stream_ctrl: RTL and testbench
====================================

Name: gauss_stream_ctrl

Overview:
- Frame sequencer for the 3x3 Gaussian filter datapath.
- Accepts a raster pixel stream, drives the shift enable for the line buffers and horizontal 3-tap windows, and tracks column/row position.
- Flags which 3x3 windows are fully inside the image, carries that flag through the filter pipeline, and applies downstream backpressure by freezing the whole datapath.
- Sits between the input stream interface and the line-buffer/window/kernel datapath.

Parameters:
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)
- COL_W, 10, column counter width (2**COL_W >= IMG_W)
- ROW_W, 9, row counter width (2**ROW_W >= IMG_H)
- PIPE_LAT, 3, kernel pipeline depth in enabled cycles from window-valid to result (>=1)

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; arms one frame
- i_s_valid  in  1  input pixel valid
- o_s_ready  out  1  controller accepts pixel this cycle
- o_win_en  out  1  shift enable to line buffers and windows (= accepted pixel)
- o_pipe_en  out  1  advance enable to kernel pipeline registers
- o_col  out  COL_W  column of the pixel accepted this cycle
- o_row  out  ROW_W  row of the pixel accepted this cycle
- o_m_valid  out  1  filtered result valid at datapath output
- o_m_last  out  1  with o_m_valid: last result of frame
- i_m_ready  in  1  downstream accepts result
- o_busy  out  1  frame in progress (RUN or DRAIN)
- o_done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; counters, valid/last shift registers, and all outputs 0. Reset mid-frame aborts the frame; no o_done.
- Stall: stall = o_m_valid & ~i_m_ready. o_pipe_en = ~stall (also 1 in IDLE).
- o_s_ready = (state==RUN) & ~stall. o_win_en = i_s_valid & o_s_ready, combinational.
- o_col/o_row are registered counters giving the position of the next pixel to accept. Per accepted pixel: col increments; at col==IMG_W-1, col->0 and row increments. They present the accepted pixel's position in the same cycle as o_win_en.
- Window valid (combinational): win_vld = o_win_en & (o_col>=2) & (o_row>=2). The window is centred at (o_col-1, o_row-1). A frame yields exactly (IMG_W-2)*(IMG_H-2) results; no border padding.
- win_last = win_vld & o_col==IMG_W-1 & o_row==IMG_H-1.
- Valid and last each pass through PIPE_LAT-stage shift registers.
  - Each stage advances only when o_pipe_en=1.
  - When o_pipe_en=1 but no window is accepted this cycle, a 0 bubble enters.
  - o_m_valid and o_m_last are the final stages.
- State machine:
  - IDLE: o_busy=0. i_start -> RUN; counters cleared.
  - RUN: accept pixels. On acceptance of pixel (IMG_W-1, IMG_H-1) -> DRAIN; counters reset to 0.
  - DRAIN: o_s_ready=0; bubbles flush the pipeline. When the final stage holds last and o_m_valid & i_m_ready -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- i_start outside IDLE is ignored (see optional feature).
- i_s_valid outside RUN is ignored; no pixel is consumed.
- Simultaneous stall and i_s_valid: pixel is not accepted; no enable is issued; counters hold.
- o_m_valid stays asserted with data stable until i_m_ready.

Optional Feature:
- Macro: GAUSS_CTRL_ERR_EN.
- Defined: adds input i_err_clr and output o_err (1 bit).
  - o_err is a sticky flag, set in the cycle after either:
    - i_start asserts while not IDLE, or
    - i_s_valid is high in IDLE or DRAIN.
  - Cleared by i_err_clr or reset. i_err_clr has priority over a simultaneous set.
- Undefined: neither port exists; both conditions are silently ignored.

Test Plan:
- IMG_W=5, IMG_H=4, PIPE_LAT=2; start, then 20 pixels with continuous valid and i_m_ready=1 -> o_win_en high 20 cycles; exactly 6 o_m_valid pulses; the first appears 2 cycles after pixel (2,2) is accepted; o_m_last on the 6th; o_done one cycle later; o_busy falls.
- Same setup, i_m_ready=0 for 4 cycles while o_m_valid=1 -> o_s_ready=0, o_win_en=0, o_pipe_en=0, counters frozen; on release, the result count is still 6 with no duplicates.
- i_s_valid toggling 1/0 every cycle -> counters step only on accepted pixels; o_col wraps 4->0 with o_row incrementing; 6 results total.
- i_rst_n asserted low at pixel 12 of a frame -> all outputs 0 asynchronously; after release, a new i_start processes a full frame with 6 results.
- i_start pulsed during RUN -> ignored; frame completes normally. With GAUSS_CTRL_ERR_EN: o_err=1 next cycle; holds until i_err_clr.
- Pixels presented in IDLE before i_start -> o_s_ready=0, o_win_en=0, counters stay 0.

Source files
------------

// File: rtl/gauss_stream_ctrl.sv
`timescale 1ns/1ps
// gauss_stream_ctrl: frame sequencer for the 3x3 Gaussian filter datapath.
// Latency: win_en/col/row are combinational with pixel acceptance; results appear
//   PIPE_LAT enabled cycles after the window is accepted.
// Backpressure: a held result (o_m_valid & ~i_m_ready) freezes the whole datapath
//   (o_pipe_en=0) and blocks input acceptance.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_start                  arms one frame (IDLE only)
//   i_s_valid / o_s_ready    input pixel handshake
//   o_win_en, o_pipe_en      shift enables for line buffers/windows and kernel pipe
//   o_col, o_row             position of the pixel accepted this cycle
//   o_m_valid/o_m_last/i_m_ready  result handshake at datapath output
//   o_busy, o_done           frame in progress / one-cycle completion pulse
// Optional macro GAUSS_CTRL_ERR_EN adds i_err_clr and the sticky protocol error o_err.
module gauss_stream_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int PIPE_LAT = 3
) (
`ifdef GAUSS_CTRL_ERR_EN
  input  logic             i_err_clr,
  output logic             o_err,
`endif
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic             o_win_en,
  output logic             o_pipe_en,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_m_valid,
  output logic             o_m_last,
  input  logic             i_m_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [1:0]          state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [PIPE_LAT-1:0] vld_q, last_q;

  logic stall;
  logic win_vld;
  logic win_last;
  logic at_col_last;
  logic at_row_last;

  // A result held at the output freezes every stage, so nothing is lost or duplicated.
  assign stall     = o_m_valid & ~i_m_ready;
  assign o_pipe_en = ~stall;
  assign o_s_ready = (state_q == ST_RUN) & ~stall;
  assign o_win_en  = i_s_valid & o_s_ready;

  assign o_col = col_q;
  assign o_row = row_q;

  assign at_col_last = (col_q == COL_LAST);
  assign at_row_last = (row_q == ROW_LAST);

  // Window centred one pixel up-left of the newest pixel; only full interior windows count.
  assign win_vld  = o_win_en & (col_q >= COL_W'(2)) & (row_q >= ROW_W'(2));
  assign win_last = win_vld & at_col_last & at_row_last;

  assign o_m_valid = vld_q[PIPE_LAT-1];
  assign o_m_last  = last_q[PIPE_LAT-1];
  assign o_busy    = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign o_done    = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (o_win_en) begin
          if (at_col_last) begin
            col_d = '0;
            if (at_row_last) begin
              row_d   = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Bubbles keep entering the pipe until the flagged last result is taken.
        if (o_m_valid & o_m_last & i_m_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Valid/last travel alongside the kernel data; a 0 bubble enters on idle enabled cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (o_pipe_en) begin
      vld_q[0]  <= win_vld;
      last_q[0] <= win_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

`ifdef GAUSS_CTRL_ERR_EN
  logic err_q, err_d;
  logic err_set;

  assign err_set = (i_start & (state_q != ST_IDLE))
                 | (i_s_valid & ((state_q == ST_IDLE) | (state_q == ST_DRAIN)));

  always_comb begin
    err_d = err_q;
    if (i_err_clr) begin
      err_d = 1'b0;
    end else if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_gauss_stream_ctrl.sv
`timescale 1ns/1ps
module tb_gauss_stream_ctrl;
  localparam int W = 5, H = 4, L = 2, CW = 3, RW = 2;
  localparam int NRES = (W - 2) * (H - 2);

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic          s_ready, win_en, pipe_en, m_valid, m_last, busy, done;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
`ifdef GAUSS_CTRL_ERR_EN
  logic err_clr = 1'b0;
  logic err;
`endif

  gauss_stream_ctrl #(.IMG_W(W), .IMG_H(H), .COL_W(CW), .ROW_W(RW), .PIPE_LAT(L)) dut (
`ifdef GAUSS_CTRL_ERR_EN
    .i_err_clr(err_clr), .o_err(err),
`endif
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_s_valid(s_valid),
    .o_s_ready(s_ready), .o_win_en(win_en), .o_pipe_en(pipe_en),
    .o_col(col), .o_row(row), .o_m_valid(m_valid), .o_m_last(m_last),
    .i_m_ready(m_ready), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { bit last; int cyc; } exp_t;
  exp_t sbq[$];

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Reference model state: pixel index within frame, frame phase, result bookkeeping.
  int k = 0, res_cnt = 0, ready_mode = 0, stall_left = 0;
  bit model_run = 0, model_busy = 0, done_pend = 0, lat_chk = 0, stalled = 0;
  bit in_stall, prev_stall = 0, prev_last = 0;
  int prev_col = 0, prev_row = 0;

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      m_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 2 && !stalled && m_valid) begin
      m_ready = 1'b0;
      stall_left = 3;
      stalled = 1;
    end else if (ready_mode == 1) begin
      m_ready = ($urandom_range(0, 3) != 0);
    end else begin
      m_ready = 1'b1;
    end
  end

  // Input-side monitor: checks handshake rules and pushes expected results.
  always @(negedge clk) begin
    if (rst_n) begin
      in_stall = m_valid & ~m_ready;
      chk("s_ready", s_ready, model_run & ~in_stall);
      chk("win_en", win_en, s_valid & model_run & ~in_stall);
      chk("pipe_en", pipe_en, !in_stall);
      if (!model_run) begin
        chk("idle_col", col, 0);
        chk("idle_row", row, 0);
      end
      if (win_en) begin
        chk("col", col, k % W);
        chk("row", row, k / W);
        if ((k % W) >= 2 && (k / W) >= 2) sbq.push_back('{k == W * H - 1, cyc_cnt});
        k++;
        if (k == W * H) begin
          k = 0;
          model_run = 0;
        end
      end
    end
  end

  // Output-side monitor: pops and compares each accepted result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("done", done, done_pend);
      chk("busy", busy, model_busy);
      done_pend = 0;
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_last", m_last, prev_last);
        chk("hold_col", col, prev_col);
        chk("hold_row", row, prev_row);
      end
      if (m_valid && m_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("m_last", m_last, e.last);
          if (lat_chk) chk("latency", cyc_cnt - e.cyc, L);
          res_cnt++;
          if (e.last) begin
            done_pend = 1;
            model_busy = 0;
          end
        end
      end
      prev_stall = m_valid & ~m_ready;
      prev_last = m_last;
      prev_col = col;
      prev_row = row;
    end else begin
      prev_stall = 0;
      done_pend = 0;
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_win_en"}, win_en, 0);
    chk({tag, "_col"}, col, 0);
    chk({tag, "_row"}, row, 0);
`ifdef GAUSS_CTRL_ERR_EN
    chk({tag, "_err"}, err, 0);
`endif
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    sbq.delete();
    k = 0; model_run = 0; model_busy = 0; res_cnt = 0; stall_left = 0;
    s_valid = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

`ifdef GAUSS_CTRL_ERR_EN
  task automatic clear_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("err_cleared", err, 0);
  endtask
`endif

  task automatic do_frame(int vmode, int rmode, int rst_at, bit start_mid);
    int guard;
    bit tog;
    ready_mode = rmode; stalled = 0; lat_chk = (rmode == 0); res_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    model_busy = 1; model_run = 1;
    guard = 0; tog = 1;
    while (model_run && guard < 1000) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = tog;
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
`ifdef GAUSS_CTRL_ERR_EN
      if (start_mid && guard == 4) chk("err_set", err, 1);
`endif
      start = (start_mid && guard == 3);
      @(posedge clk); #1;
      guard++;
      if (rst_at >= 0 && k == rst_at) begin
        do_reset();
        return;
      end
    end
    s_valid = 1'b0; start = 1'b0;
    chk("run_timeout", guard >= 1000, 0);
    guard = 0;
    while (model_busy && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_timeout", guard >= 500, 0);
    @(posedge clk); #1;
    chk("result_count", res_cnt, NRES);
    chk("queue_empty", sbq.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;

    // Pixels offered while idle must be ignored.
    s_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 s_valid = 1'b0;
`ifdef GAUSS_CTRL_ERR_EN
    chk("err_idle_pixel", err, 1);
    clear_err();
`endif

    do_frame(0, 0, -1, 0);   // continuous stream, always ready
    do_frame(0, 2, -1, 0);   // one 4-cycle downstream stall
    do_frame(1, 0, -1, 0);   // valid toggling every cycle
    do_frame(0, 0, 12, 0);   // reset after 12 pixels
    do_frame(0, 0, -1, 0);   // full frame after reset
    do_frame(0, 0, -1, 1);   // stray start during RUN
`ifdef GAUSS_CTRL_ERR_EN
    chk("err_sticky", err, 1);
    clear_err();
`endif
    for (int i = 0; i < 3; i++) do_frame(2, 1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
